phaethon_cpu: RTL and testbench

- Multi-cycle 32-bit CPU core: fetches and executes instructions from an external byte-addressed, little-endian RAM.
- Byte-wide UART access through request/acknowledge (read) and request/ready (write) handshakes.
- Top-level processing element; RAM and UART live outside the block.

---
 rtl/phaethon_cpu_if.sv | 23 ++
 rtl/phaethon_cpu.sv | 161 ++++++++++++++++
 tb/tb_phaethon_cpu.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/phaethon_cpu_if.sv
// RAM and UART handshake bundle between the phaethon_cpu core and its memory/UART neighbours.
interface phaethon_cpu_if;
  logic [31:0] ramIn;
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic        readReq;
  logic        writeReq;
  logic        uartReadReq;
  logic        uartReadAck;
  logic [7:0]  uartReadData;
  logic        uartWriteReq;
  logic [7:0]  uartWriteData;
  logic        uartWriteReady;

  modport master (
    input  ramIn, uartReadAck, uartReadData, uartWriteReady,
    output ramAddress, ramOut, readReq, writeReq, uartReadReq, uartWriteReq, uartWriteData
  );
  modport slave (
    output ramIn, uartReadAck, uartReadData, uartWriteReady,
    input  ramAddress, ramOut, readReq, writeReq, uartReadReq, uartWriteReq, uartWriteData
  );
endinterface

// File: rtl/phaethon_cpu.sv
// Multi-cycle 32-bit core: 16 GPRs, byte-addressed little-endian RAM, byte UART.
// All bus outputs are registered and set on the edge that enters the state using them.
module phaethon_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  phaethon_cpu_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, IMM_REQ, IMM_EXEC, MEM_REQ, MEM_WB, MEM_ST, UART_RD, UART_WR, HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [15:0] ir;
  logic [31:0] gpr [16];

  logic        read_req, write_req, uart_rd_req, uart_wr_req;
  logic [31:0] ram_address, ram_out;
  logic [7:0]  uart_wr_data;

  // In DECODE the instruction is still on ramIn; later states use the latched IR.
  logic [15:0] instr;
  logic [7:0]  op;
  logic [3:0]  ra_i, rb_i;
  logic [31:0] ra_v, rb_v, alu, pc4, imm;
  logic        is_reg_op, taken;

  assign instr = (state == DECODE) ? bus.ramIn[15:0] : ir;
  assign op    = instr[7:0];
  assign ra_i  = instr[11:8];
  assign rb_i  = instr[15:12];
  assign ra_v  = gpr[ra_i];
  assign rb_v  = gpr[rb_i];
  assign pc4   = pc + 32'd4;
  assign imm   = bus.ramIn;

  always_comb begin
    alu       = ra_v;
    is_reg_op = 1'b1;
    case (op)
      8'h02:   alu = rb_v;
      8'h03:   alu = ra_v + rb_v;
      8'h04:   alu = ra_v - rb_v;
      8'h05:   alu = ra_v & rb_v;
      8'h06:   alu = ra_v | rb_v;
      8'h07:   alu = ra_v ^ rb_v;
      default: is_reg_op = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (op)
      8'h0B:   taken = 1'b1;
      8'h0C:   taken = (ra_v == 32'd0);
      8'h0D:   taken = (ra_v != 32'd0);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      ir           <= '0;
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
      read_req     <= 1'b0;
      write_req    <= 1'b0;
      uart_rd_req  <= 1'b0;
      uart_wr_req  <= 1'b0;
      ram_address  <= '0;
      ram_out      <= '0;
      uart_wr_data <= '0;
    end else begin
      read_req     <= 1'b0;
      write_req    <= 1'b0;
      uart_wr_req  <= 1'b0;
      ram_address  <= '0;
      ram_out      <= '0;
      uart_wr_data <= '0;
      case (state)
        FETCH: begin
          // read_req is low here only on the first cycle after reset
          if (read_req) state <= DECODE;
          else begin
            read_req    <= 1'b1;
            ram_address <= pc;
          end
        end
        DECODE: begin
          ir <= bus.ramIn[15:0];
          pc <= pc4;
          case (op)
            8'h01, 8'h08, 8'h0B, 8'h0C, 8'h0D: begin
              state <= IMM_REQ; read_req <= 1'b1; ram_address <= pc4;
            end
            8'h09: begin
              state <= MEM_REQ; read_req <= 1'b1; ram_address <= rb_v;
            end
            8'h0A: begin
              state <= MEM_ST; write_req <= 1'b1; ram_address <= rb_v; ram_out <= ra_v;
            end
            8'h0E: begin
              state <= UART_RD; uart_rd_req <= 1'b1;
            end
            8'h0F:   state <= UART_WR;
            8'h10:   state <= HALT;
            default: begin
              if (is_reg_op) gpr[ra_i] <= alu;
              state <= FETCH; read_req <= 1'b1; ram_address <= pc4;
            end
          endcase
        end
        IMM_REQ: state <= IMM_EXEC;
        IMM_EXEC: begin
          if (op == 8'h01) gpr[ra_i] <= imm;
          if (op == 8'h08) gpr[ra_i] <= ra_v + imm;
          pc          <= taken ? imm : pc4;
          ram_address <= taken ? imm : pc4;
          read_req    <= 1'b1;
          state       <= FETCH;
        end
        MEM_REQ: state <= MEM_WB;
        MEM_WB: begin
          gpr[ra_i] <= bus.ramIn;
          state <= FETCH; read_req <= 1'b1; ram_address <= pc;
        end
        MEM_ST: begin
          state <= FETCH; read_req <= 1'b1; ram_address <= pc;
        end
        UART_RD: begin
          if (uart_rd_req && bus.uartReadAck) begin
            gpr[ra_i]   <= {24'b0, bus.uartReadData};
            uart_rd_req <= 1'b0;
            state <= FETCH; read_req <= 1'b1; ram_address <= pc;
          end
        end
        UART_WR: begin
          if (uart_wr_req) begin
            state <= FETCH; read_req <= 1'b1; ram_address <= pc;
          end else if (bus.uartWriteReady) begin
            uart_wr_req  <= 1'b1;
            uart_wr_data <= ra_v[7:0];
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.readReq       = read_req;
  assign bus.writeReq      = write_req;
  assign bus.ramAddress    = ram_address;
  assign bus.ramOut        = ram_out;
  assign bus.uartReadReq   = uart_rd_req;
  assign bus.uartWriteReq  = uart_wr_req;
  assign bus.uartWriteData = uart_wr_data;
endmodule

// File: tb/tb_phaethon_cpu.sv
// Directed programs for phaethon_cpu; RAM and UART write/read events are scored against a queue.
module tb_phaethon_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  phaethon_cpu_if bus ();
  phaethon_cpu #(.RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] mem [0:4095];

  typedef struct {
    logic        uart;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t sb [$];

  logic [31:0] rd_log [$];
  int checks = 0, passes = 0, fails = 0;
  int loop_fetch = 0, req_cnt = 0, conflict = 0, uw_cnt = 0;
  int pa = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM model: registered read, little-endian byte writes
  always @(posedge clk) begin
    if (bus.readReq)
      bus.ramIn <= {mem[bus.ramAddress[11:0] + 12'd3], mem[bus.ramAddress[11:0] + 12'd2],
                    mem[bus.ramAddress[11:0] + 12'd1], mem[bus.ramAddress[11:0]]};
    if (bus.writeReq)
      for (int k = 0; k < 4; k++) mem[bus.ramAddress[11:0] + 12'(k)] <= bus.ramOut[8*k +: 8];
  end

  // UART receive side acks one cycle after seeing the request
  always @(posedge clk) begin
    if (reset) bus.uartReadAck <= 1'b0;
    else       bus.uartReadAck <= bus.uartReadReq && !bus.uartReadAck;
  end

  task automatic check_ev(input logic uart, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    if (sb.size() == 0) begin
      checks++; fails++;
      $display("FAIL unexpected_event: got uart=%0d addr=%h data=%h expected none", uart, addr, data);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", {31'd0, uart}, {31'd0, e.uart});
      chk("ev_addr", addr, e.addr);
      chk("ev_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.readReq) begin
        rd_log.push_back(bus.ramAddress);
        if (bus.ramAddress == 32'h8) loop_fetch++;
      end
      if (bus.readReq || bus.writeReq || bus.uartReadReq || bus.uartWriteReq) req_cnt++;
      if (bus.readReq && bus.writeReq) conflict++;
      if (bus.writeReq) check_ev(1'b0, bus.ramAddress, bus.ramOut);
      if (bus.uartWriteReq) begin
        uw_cnt++;
        check_ev(1'b1, 32'h0, {24'h0, bus.uartWriteData});
      end
    end
  end

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b);
    return {16'h0, b, a, op};
  endfunction

  task automatic emit(input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[pa + k] = w[8*k +: 8];
    pa += 4;
  endtask

  task automatic movi(input logic [3:0] a, input logic [31:0] v);
    emit(ins(8'h01, a, 4'h0));
    emit(v);
  endtask

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.uart = 1'b0; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic expect_uw(input logic [7:0] data);
    ev_t e;
    e.uart = 1'b1; e.addr = 32'h0; e.data = {24'h0, data};
    sb.push_back(e);
  endtask

  // Holds reset, clears RAM and logs; program is loaded afterwards, then go() releases reset.
  task automatic begin_prog();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
    rd_log.delete();
    sb.delete();
    pa = 0; loop_fetch = 0; uw_cnt = 0;
  endtask

  task automatic go(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int snap;
    bit hit;
    bus.ramIn = '0; bus.uartReadAck = 1'b0;
    bus.uartReadData = 8'hAB; bus.uartWriteReady = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.readReq, bus.writeReq, bus.uartReadReq, bus.uartWriteReq, bus.ramAddress},
        {4'b0, 32'h0});

    // 1: MOVI/MOVI/ADD/ST, fetch address sequence
    begin_prog();
    movi(4'd1, 32'h1234_5678);
    movi(4'd2, 32'h0000_0088);
    emit(ins(8'h03, 4'd1, 4'd2));
    emit(ins(8'h0A, 4'd1, 4'd0));
    emit(ins(8'h10, 4'd0, 4'd0));
    expect_wr(32'h0, 32'h1234_5700);
    go(40);
    for (int k = 0; k < 6; k++)
      chk($sformatf("fetch_addr%0d", k), (rd_log.size() > k) ? rd_log[k] : 32'hFFFF_FFFF, 32'(4 * k));
    chk("t1_queue_left", sb.size(), 0);

    // 2: wraparound arithmetic and logic ops
    begin_prog();
    movi(4'd1, 32'hFFFF_FFFF); movi(4'd2, 32'h1); movi(4'd3, 32'h200);
    emit(ins(8'h03, 4'd1, 4'd2)); emit(ins(8'h0A, 4'd1, 4'd3));
    movi(4'd4, 32'h0);
    emit(ins(8'h04, 4'd4, 4'd2)); emit(ins(8'h0A, 4'd4, 4'd3));
    movi(4'd5, 32'hF0F0_F0F0); movi(4'd6, 32'hFFFF_0000);
    emit(ins(8'h07, 4'd5, 4'd6)); emit(ins(8'h0A, 4'd5, 4'd3));
    emit(ins(8'h02, 4'd7, 4'd5)); emit(ins(8'h05, 4'd7, 4'd6)); emit(ins(8'h0A, 4'd7, 4'd3));
    emit(ins(8'h06, 4'd5, 4'd6)); emit(ins(8'h0A, 4'd5, 4'd3));
    emit(ins(8'h10, 4'd0, 4'd0));
    expect_wr(32'h200, 32'h0000_0000);
    expect_wr(32'h200, 32'hFFFF_FFFF);
    expect_wr(32'h200, 32'h0F0F_F0F0);
    expect_wr(32'h200, 32'h0F0F_0000);
    expect_wr(32'h200, 32'hFFFF_F0F0);
    go(200);
    chk("t2_queue_left", sb.size(), 0);

    // 3: store then load back
    begin_prog();
    movi(4'd1, 32'hDEAD_BEEF); movi(4'd2, 32'h100);
    emit(ins(8'h0A, 4'd1, 4'd2));
    emit(ins(8'h09, 4'd3, 4'd2));
    movi(4'd4, 32'h300);
    emit(ins(8'h0A, 4'd3, 4'd4));
    emit(ins(8'h10, 4'd0, 4'd0));
    expect_wr(32'h100, 32'hDEAD_BEEF);
    expect_wr(32'h300, 32'hDEAD_BEEF);
    go(80);
    chk("byte_100", {24'h0, mem[12'h100]}, 32'hEF);
    chk("byte_101", {24'h0, mem[12'h101]}, 32'hBE);
    chk("byte_102", {24'h0, mem[12'h102]}, 32'hAD);
    chk("byte_103", {24'h0, mem[12'h103]}, 32'hDE);
    chk("t3_queue_left", sb.size(), 0);

    // 4: countdown loop, UART send, then halt silence
    begin_prog();
    movi(4'd1, 32'd3);
    emit(ins(8'h08, 4'd1, 4'd0)); emit(32'hFFFF_FFFF);
    emit(ins(8'h0D, 4'd1, 4'd0)); emit(32'h8);
    emit(ins(8'h0F, 4'd1, 4'd0));
    emit(ins(8'h10, 4'd0, 4'd0));
    expect_uw(8'h00);
    go(100);
    chk("loop_iters", loop_fetch, 3);
    chk("t4_uart_sends", uw_cnt, 1);
    snap = req_cnt;
    repeat (30) @(negedge clk);
    chk("halt_idle_reqs", req_cnt - snap, 0);
    chk("t4_queue_left", sb.size(), 0);

    // 5: UART read, then a send that stalls on ready
    begin_prog();
    bus.uartWriteReady = 1'b0;
    movi(4'd3, 32'h200);
    emit(ins(8'h0E, 4'd2, 4'd0));
    emit(ins(8'h0A, 4'd2, 4'd3));
    emit(ins(8'h0F, 4'd2, 4'd0));
    emit(ins(8'h10, 4'd0, 4'd0));
    expect_wr(32'h200, 32'h0000_00AB);
    expect_uw(8'hAB);
    go(60);
    chk("uw_before_ready", uw_cnt, 0);
    bus.uartWriteReady = 1'b1;
    repeat (20) @(negedge clk);
    chk("uw_after_ready", uw_cnt, 1);
    chk("t5_queue_left", sb.size(), 0);

    // 6: reset during LD MEM_REQ
    begin_prog();
    movi(4'd2, 32'h100);
    emit(ins(8'h09, 4'd1, 4'd2));
    emit(ins(8'h10, 4'd0, 4'd0));
    mem[12'h100] = 8'h55;
    reset = 1'b0;
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (bus.readReq && bus.ramAddress == 32'h100) hit = 1;
    end
    chk("mem_req_seen", {31'd0, hit}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_ld_outputs",
        {bus.readReq, bus.writeReq, bus.uartReadReq, bus.uartWriteReq, bus.uartWriteData, bus.ramAddress},
        {4'b0, 8'h0, 32'h0});
    chk("reset_mid_ld_ramout", bus.ramOut, 32'h0);
    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
    pa = 0;
    emit(ins(8'h0A, 4'd1, 4'd0));
    emit(ins(8'h10, 4'd0, 4'd0));
    rd_log.delete();
    sb.delete();
    expect_wr(32'h0, 32'h0);
    go(20);
    chk("first_fetch_after_reset", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, 32'h0);
    chk("t6_queue_left", sb.size(), 0);

    chk("rd_wr_overlap", conflict, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
